// File: rtl/aes_stream_if.sv
// aes_stream_if: assembles 32-bit key/data words into 128-bit groups for an AES core
// and streams the 128-bit result back out as four 32-bit words, MS word first.
module aes_stream_if #(
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_is_key,
    input  logic         mode,
    output logic         aes_start,
    output logic         aes_enc_dec,
    output logic [127:0] aes_key,
    output logic [127:0] aes_data,
    input  logic         aes_done,
    input  logic [127:0] aes_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         key_loaded,
    output logic         busy,
    output logic         err
);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} state_t;
    state_t        state;
    logic [1:0]    wcnt;
    logic [1:0]    ocnt;
    logic          gtype;
    logic          aes_done_q;
    logic [TW-1:0] tcnt;
    logic [127:0]  result;
    logic          mixed;
    // A word inside a partial group is always taken so that a type mix can be flagged.
    assign in_ready = (state == IDLE) && (in_is_key || key_loaded || wcnt != 2'd0);
    assign mixed    = (wcnt != 2'd0) && (in_is_key != gtype);
    assign busy     = state != IDLE;
    assign out_data = result[{~ocnt, 5'b0} +: 32];
    assign out_last = out_valid && ocnt == 2'd3;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wcnt        <= '0;
            ocnt        <= '0;
            gtype       <= 1'b0;
            aes_done_q  <= 1'b0;
            tcnt        <= '0;
            result      <= '0;
            aes_key     <= '0;
            aes_data    <= '0;
            key_loaded  <= 1'b0;
            aes_start   <= 1'b0;
            aes_enc_dec <= 1'b0;
            out_valid   <= 1'b0;
            err         <= 1'b0;
        end else begin
            aes_start  <= 1'b0;
            err        <= 1'b0;
            aes_done_q <= aes_done;
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    if (mixed) begin
                        err  <= 1'b1;
                        wcnt <= '0;
                    end else begin
                        gtype <= in_is_key;
                        wcnt  <= wcnt + 2'd1;
                        if (in_is_key) begin
                            aes_key    <= {aes_key[95:0], in_data};
                            key_loaded <= wcnt == 2'd3;
                        end else begin
                            aes_data <= {aes_data[95:0], in_data};
                            if (wcnt == 2'd3) begin
                                aes_enc_dec <= mode;
                                aes_start   <= 1'b1;
                                state       <= START;
                            end
                        end
                    end
                end
                START: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                // Only a rising edge of aes_done completes; a level held from before is ignored.
                WAIT: if (aes_done && !aes_done_q) begin
                    result    <= aes_result;
                    out_valid <= 1'b1;
                    state     <= DRAIN;
                end else if (tcnt == TW'(DONE_TIMEOUT - 1)) begin
                    err   <= 1'b1;
                    state <= IDLE;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                DRAIN: if (out_ready) begin
                    ocnt <= ocnt + 2'd1;
                    if (ocnt == 2'd3) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
